// File: rtl/redma_pkg.sv
// rtl/redma_pkg.sv - shared state type and AXI constants for the DMA read/write engines
package redma_pkg;

   typedef enum logic [1:0] {
      RE_IDLE  = 2'd0,
      RE_ISSUE = 2'd1,
      RE_DRAIN = 2'd2,
      RE_DONE  = 2'd3
   } ReadEngState_t;

   localparam logic [1:0] AXI_BURST_INCR = 2'b01;
   localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
   localparam int         AXI_4K_BYTES   = 4096;

endpackage

// File: rtl/axi_burst_calc.sv
// rtl/axi_burst_calc.sv - burst length = min(max len, beats left, beats to next 4KB page)
module axi_burst_calc
   import redma_pkg::*;
#(
   parameter int BEAT_WIDTH     = 27,
   parameter int BYTES_PER_BEAT = 64,
   parameter int MAX_BURST_LEN  = 64
) (
   input  logic [11:0]           page_off,
   input  logic [BEAT_WIDTH-1:0] beats_left,
   output logic [8:0]            len
);

   localparam int OFF = $clog2(BYTES_PER_BEAT);
   localparam int CW  = (BEAT_WIDTH > 13) ? BEAT_WIDTH : 13;

   logic [12:0]   bytes_to_bound;
   logic [CW-1:0] to_bound;
   logic [CW-1:0] left_ext;
   logic [CW-1:0] max_ext;
   logic [CW-1:0] lim;

   // page_off is beat aligned, so the shift is exact
   assign bytes_to_bound = 13'(AXI_4K_BYTES) - {1'b0, page_off};
   assign to_bound       = CW'(bytes_to_bound >> OFF);
   assign left_ext       = CW'(beats_left);
   assign max_ext        = CW'(MAX_BURST_LEN);

   always_comb begin
      lim = max_ext;
      if (left_ext < lim) lim = left_ext;
      if (to_bound < lim) lim = to_bound;
      len = 9'(lim);
   end

endmodule

// File: rtl/axi_read_engine.sv
// rtl/axi_read_engine.sv - splits (start_addr, btt) into AXI4 INCR reads, forwards R beats as a stream
module axi_read_engine
   import redma_pkg::*;
#(
   parameter int ADDR_WIDTH      = 64,
   parameter int BTT_WIDTH       = 32,
   parameter int DATA_WIDTH      = 512,
   parameter int MAX_BURST_LEN   = 64,
   parameter int MAX_OUTSTANDING = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] start_addr,
   input  logic [BTT_WIDTH-1:0]  btt,
   output logic                  busy,
   output logic                  done,
   output logic                  rd_error,
   output logic [ADDR_WIDTH-1:0] m_axi_araddr,
   output logic [7:0]            m_axi_arlen,
   output logic [2:0]            m_axi_arsize,
   output logic [1:0]            m_axi_arburst,
   output logic                  m_axi_arvalid,
   input  logic                  m_axi_arready,
   input  logic [DATA_WIDTH-1:0] m_axi_rdata,
   input  logic [1:0]            m_axi_rresp,
   input  logic                  m_axi_rlast,
   input  logic                  m_axi_rvalid,
   output logic                  m_axi_rready,
   output logic [DATA_WIDTH-1:0] out_tdata,
   output logic                  out_tvalid,
   output logic                  out_tlast,
   input  logic                  out_tready
);

   localparam int BPB = DATA_WIDTH / 8;
   localparam int OFF = $clog2(BPB);
   localparam int BW  = BTT_WIDTH - OFF + 1;
   localparam int OW  = $clog2(MAX_OUTSTANDING + 1);

   ReadEngState_t         state, state_nxt;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [BW-1:0]         beats_total, beats_left, beat_cnt, btt_beats;
   logic [OW-1:0]         outstanding;
   logic [BTT_WIDTH:0]    btt_round;
   logic [8:0]            burst_len, burst_len_m1;
   logic                  start_acc, ar_hs, r_hs, r_last_hs;
   logic                  unused_resp_lsb;

   assign btt_round       = {1'b0, btt} + (BTT_WIDTH+1)'(BPB - 1);
   assign btt_beats       = btt_round[BTT_WIDTH:OFF];
   assign start_acc       = (state == RE_IDLE) && start;
   assign ar_hs           = m_axi_arvalid && m_axi_arready;
   assign r_hs            = m_axi_rvalid && m_axi_rready;
   assign r_last_hs       = r_hs && m_axi_rlast;
   assign unused_resp_lsb = m_axi_rresp[0];

   axi_burst_calc #(
      .BEAT_WIDTH    (BW),
      .BYTES_PER_BEAT(BPB),
      .MAX_BURST_LEN (MAX_BURST_LEN)
   ) u_burst_calc (
      .page_off  (addr_q[11:0]),
      .beats_left(beats_left),
      .len       (burst_len)
   );

   // AR fields come only from registers, so they hold steady while arvalid waits
   assign burst_len_m1  = burst_len - 9'd1;
   assign m_axi_araddr  = addr_q;
   assign m_axi_arlen   = burst_len_m1[7:0];
   assign m_axi_arsize  = 3'(OFF);
   assign m_axi_arburst = AXI_BURST_INCR;

   assign m_axi_rready  = out_tready;
   assign out_tdata     = m_axi_rdata;
   assign out_tvalid    = m_axi_rvalid;
   assign out_tlast     = (beats_total != '0) && (beat_cnt == beats_total - BW'(1));

   always_ff @(posedge clk) begin
      if (rst) state <= RE_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         RE_IDLE:  if (start) state_nxt = (btt_beats == '0) ? RE_DONE : RE_ISSUE;
         RE_ISSUE: if (ar_hs && (beats_left == BW'(burst_len))) state_nxt = RE_DRAIN;
         RE_DRAIN: if (outstanding == '0) state_nxt = RE_DONE;
         RE_DONE:  state_nxt = RE_IDLE;
         default:  state_nxt = RE_IDLE;
      endcase
   end

   always_comb begin
      busy          = 1'b0;
      done          = 1'b0;
      m_axi_arvalid = 1'b0;
      case (state)
         RE_ISSUE: begin
            busy          = 1'b1;
            m_axi_arvalid = (outstanding < OW'(MAX_OUTSTANDING));
         end
         RE_DRAIN: busy = 1'b1;
         RE_DONE: begin
            busy = 1'b1;
            done = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         addr_q      <= '0;
         beats_total <= '0;
         beats_left  <= '0;
         beat_cnt    <= '0;
         outstanding <= '0;
         rd_error    <= 1'b0;
      end else begin
         if (start_acc) begin
            addr_q      <= start_addr & ~ADDR_WIDTH'(BPB - 1);
            beats_total <= btt_beats;
            beats_left  <= btt_beats;
            beat_cnt    <= '0;
            rd_error    <= 1'b0;
         end else begin
            if (ar_hs) begin
               addr_q     <= addr_q + (ADDR_WIDTH'(burst_len) << OFF);
               beats_left <= beats_left - BW'(burst_len);
            end
            if (r_hs) begin
               beat_cnt <= beat_cnt + BW'(1);
               if (m_axi_rresp[1]) rd_error <= 1'b1;
            end
         end
         if (ar_hs && !r_last_hs)
            outstanding <= outstanding + OW'(1);
         else if (!ar_hs && r_last_hs && (outstanding != '0))
            outstanding <= outstanding - OW'(1);
      end
   end

endmodule
